// File: rtl/fetch_defs.sv
// Shared definitions for the fetch stage: default widths, the NOP encoding
// presented when no instruction is valid, and the fetch FSM state encoding.
package fetch_defs;
    localparam int          ADDR_W_DEF   = 16;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {word, pc} pairs between instruction memory and
// the decoder. Flush wins over push and pop.
module fetch_buf
    import fetch_defs::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [31:0]       push_word_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o,
    output logic [31:0]       head_word_o,
    output logic [ADDR_W-1:0] head_pc_o
);
    logic [31:0]       word_q [2];
    logic [ADDR_W-1:0] pc_q   [2];
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q[0] <= '0;
            word_q[1] <= '0;
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            count_q   <= 2'd0;
        end else if (flush_i) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            // When full, wr == rd: the overwritten slot is the head being popped.
            if (push_i) begin
                word_q[wr_q] <= push_word_i;
                pc_q[wr_q]   <= push_pc_i;
                wr_q         <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign full_o      = (count_q == 2'd2);
    assign empty_o     = (count_q == 2'd0);
    assign count_o     = count_q;
    assign head_word_o = word_q[rd_q];
    assign head_pc_o   = pc_q[rd_q];
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and hands
// buffered {word, pc} pairs to the decoder; halts on pc_halt, restarts on redirect.
//   state     | meaning
//   ST_RUN    | issue a read whenever buffered + outstanding < 2
//   ST_WAIT   | one read outstanding; req/addr held until ack
//   ST_HALTED | decoder saw HALT; idle until redirect
module instr_fetch
    import fetch_defs::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              discard_q, discard_d;
    logic              halted_q, halted_d;
    logic              live_q;

    logic              buf_push, buf_pop, buf_flush, buf_full, buf_empty;
    logic [1:0]        buf_count;
    logic [31:0]       head_word;
    logic [ADDR_W-1:0] head_pc;
    logic              take_data, pending, halt_take;

    fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (buf_push),
        .push_word_i (imem_rdata),
        .push_pc_i   (imem_addr),
        .pop_i       (buf_pop),
        .flush_i     (buf_flush),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count),
        .head_word_o (head_word),
        .head_pc_o   (head_pc)
    );

    // live_q keeps req low while in reset and for the first edge after it.
    assign imem_req    = live_q & ((state_q == ST_WAIT) |
                                   ((state_q == ST_RUN) & (buf_count < 2'd2)));
    assign imem_addr   = (state_q == ST_WAIT) ? addr_q : fetch_pc_q;
    assign instr_valid = ~buf_empty;
    assign instr       = instr_valid ? head_word : NOP_WORD;
    assign instr_pc    = instr_valid ? head_pc : '0;
    assign halted      = halted_q;
    assign halt_take   = pc_halt & instr_valid;
    assign buf_pop     = instr_valid & instr_ready;
    assign pending     = imem_req & ~imem_ack;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        halted_d   = halted_q;
        take_data  = 1'b0;
        buf_flush  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (imem_req) begin
                    if (imem_ack) begin
                        take_data  = 1'b1;
                        fetch_pc_d = fetch_pc_q + 1'b1;
                    end else begin
                        addr_d  = fetch_pc_q;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        take_data  = 1'b1;
                        fetch_pc_d = addr_q + 1'b1;
                    end
                    state_d = halted_q ? ST_HALTED : ST_RUN;
                end
            end
            default: ;
        endcase

        // A read still in flight must drain in WAIT; its data is marked stale.
        if (redirect) begin
            buf_flush  = 1'b1;
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            discard_d  = pending;
            state_d    = pending ? ST_WAIT : ST_RUN;
        end else if (halt_take) begin
            buf_flush  = 1'b1;
            fetch_pc_d = instr_pc + 1'b1;
            halted_d   = 1'b1;
            discard_d  = pending;
            state_d    = pending ? ST_WAIT : ST_HALTED;
        end
    end

    assign buf_push = take_data & ~buf_flush & (~buf_full | buf_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            discard_q  <= 1'b0;
            halted_q   <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
            live_q     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked
// against an in-order PC-stream model of what the decoder should receive.
module tb_instr_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        rst_n = 1'b0, imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0;
    logic        pc_halt = 1'b0, redirect = 1'b0, halted;
    logic [15:0] imem_addr, instr_pc, redirect_pc = '0;
    logic [31:0] imem_rdata = '0, instr;

    logic        rst2_n = 1'b0, imem_req2, imem_ack2 = 1'b0, instr_valid2, halted2;
    logic [15:0] imem_addr2, instr_pc2;
    logic [31:0] imem_rdata2 = '0, instr2;

    instr_fetch #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_halt(pc_halt),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
    );

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .instr_ready(1'b1), .pc_halt(1'b0),
        .redirect(1'b0), .redirect_pc(16'h0000), .halted(halted2)
    );

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {~a, a} ^ 32'h1234_0000;
    endfunction

    // Memory model for dut: acks after mem_lat idle cycles (3 for slow_addr).
    int          mem_cnt = 0;
    int          mem_lat = 0;
    logic [15:0] slow_addr = 16'hFFFF;

    task automatic step();
        int lat;
        @(negedge clk);
        lat = (imem_addr == slow_addr) ? 3 : mem_lat;
        if (imem_req) begin
            if (mem_cnt >= lat) begin
                imem_ack = 1'b1; imem_rdata = word_of(imem_addr); mem_cnt = 0;
            end else begin
                imem_ack = 1'b0; mem_cnt++;
            end
        end else begin
            imem_ack = 1'b0; mem_cnt = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; instr_ready = 1'b0; pc_halt = 1'b0; redirect = 1'b0;
        mem_lat = 0; slow_addr = 16'hFFFF; mem_cnt = 0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input logic [15:0] a, input string name);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < 40) begin step(); n++; end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL %s: no req for addr %0h (last addr %0h)", name, a, imem_addr); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; step();
        #2 rst_n = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %0h want 0", instr); end
        checks++; if (instr_pc !== 16'h0) begin failures++; $display("FAIL reset_pc: got %0h want 0", instr_pc); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_stream();
        do_reset(); instr_ready = 1'b1;
        wait_req(16'h0, "stream_start");
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid: got %b want 0", instr_valid); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (!(imem_req === 1'b1 && imem_addr === 16'(k))) begin
                failures++; $display("FAIL stream_addr: got req=%b addr=%0h want addr %0h", imem_req, imem_addr, k);
            end
            if (k > 0) begin
                checks++;
                if (!(instr_valid === 1'b1 && instr_pc === 16'(k-1) && instr === word_of(16'(k-1)))) begin
                    failures++; $display("FAIL stream_head: got v=%b pc=%0h w=%0h want pc %0h", instr_valid, instr_pc, instr, k-1);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp;
        int consumed = 0;
        do_reset();
        wait_req(16'h0, "bp_start");
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) begin
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_stall: got %b want 0", imem_req); end
            end
            step();
        end
        checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 16'h0 && imem_req === 1'b0)) begin
            failures++; $display("FAIL bp_hold: got v=%b pc=%0h req=%b want 1/0/0", instr_valid, instr_pc, imem_req);
        end
        instr_ready = 1'b1; exp = 16'h0;
        for (int c = 0; c < 8; c++) begin
            if (instr_valid) begin
                checks++;
                if (!(instr_pc === exp && instr === word_of(exp))) begin
                    failures++; $display("FAIL bp_order: got pc=%0h w=%0h want pc %0h", instr_pc, instr, exp);
                end
                exp++; consumed++;
            end
            step();
        end
        checks++; if (consumed != 8) begin failures++; $display("FAIL bp_count: got %0d words want 8", consumed); end
    endtask

    task automatic test_late_ack();
        do_reset(); instr_ready = 1'b1; slow_addr = 16'h0005;
        wait_req(16'h5, "late_start");
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (!(imem_req === 1'b1 && imem_addr === 16'h5)) begin
                failures++; $display("FAIL late_hold: got req=%b addr=%0h want 1/5", imem_req, imem_addr);
            end
            if (s > 0) begin
                checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL late_early: got valid %b want 0", instr_valid); end
            end
            step();
        end
        checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 16'h5 && instr === word_of(16'h5))) begin
            failures++; $display("FAIL late_arrive: got v=%b pc=%0h want pc 5", instr_valid, instr_pc);
        end
        slow_addr = 16'hFFFF;
    endtask

    task automatic test_halt_redirect();
        do_reset(); instr_ready = 1'b1; slow_addr = 16'h0008;
        wait_req(16'h8, "halt_start");
        checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 16'h7)) begin
            failures++; $display("FAIL halt_head: got v=%b pc=%0h want pc 7", instr_valid, instr_pc);
        end
        pc_halt = 1'b1; step(); pc_halt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (!(halted === 1'b1 && instr_valid === 1'b0 && instr === 32'h0)) begin
                failures++; $display("FAIL halt_state: got halted=%b v=%b instr=%0h want 1/0/0", halted, instr_valid, instr);
            end
            checks++;
            if (imem_req !== (i < 3) || (imem_req && imem_addr !== 16'h8)) begin
                failures++; $display("FAIL halt_req: got req=%b addr=%0h want req %0b addr 8", imem_req, imem_addr, i < 3);
            end
            step();
        end
        slow_addr = 16'hFFFF; redirect = 1'b1; redirect_pc = 16'h0040;
        step(); redirect = 1'b0;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL redir_halted: got %b want 0", halted); end
        checks++;
        if (!(imem_req === 1'b1 && imem_addr === 16'h0040)) begin
            failures++; $display("FAIL redir_req: got req=%b addr=%0h want 1/40", imem_req, imem_addr);
        end
        step();
        checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 16'h0040 && instr === word_of(16'h0040))) begin
            failures++; $display("FAIL redir_head: got v=%b pc=%0h want pc 40", instr_valid, instr_pc);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset(); instr_ready = 1'b1; slow_addr = 16'h0003;
        wait_req(16'h3, "rw_start");
        step();
        redirect = 1'b1; redirect_pc = 16'h0020;
        for (int s = 1; s < 4; s++) begin
            checks++;
            if (!(imem_req === 1'b1 && imem_addr === 16'h3)) begin
                failures++; $display("FAIL rw_hold: got req=%b addr=%0h want 1/3", imem_req, imem_addr);
            end
            if (s > 1) begin
                checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rw_flush: got valid %b want 0", instr_valid); end
            end
            step(); redirect = 1'b0;
        end
        checks++;
        if (!(imem_req === 1'b1 && imem_addr === 16'h0020)) begin
            failures++; $display("FAIL rw_new_req: got req=%b addr=%0h want 1/20", imem_req, imem_addr);
        end
        step();
        checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 16'h0020 && instr === word_of(16'h0020))) begin
            failures++; $display("FAIL rw_head: got v=%b pc=%0h want pc 20", instr_valid, instr_pc);
        end
        slow_addr = 16'hFFFF;
    endtask

    task automatic test_wrap();
        int n = 0;
        rst2_n = 1'b0; imem_ack2 = 1'b0; step();
        checks++;
        if (!(imem_req2 === 1'b0 && imem_addr2 === 16'hFFFF)) begin
            failures++; $display("FAIL wrap_reset: got req=%b addr=%0h want 0/ffff", imem_req2, imem_addr2);
        end
        rst2_n = 1'b1;
        while (!imem_req2 && n < 10) begin step(); n++; end
        checks++;
        if (!(imem_req2 === 1'b1 && imem_addr2 === 16'hFFFF)) begin
            failures++; $display("FAIL wrap_first: got req=%b addr=%0h want 1/ffff", imem_req2, imem_addr2);
        end
        imem_ack2 = 1'b1; imem_rdata2 = word_of(16'hFFFF);
        step(); imem_ack2 = 1'b0;
        checks++;
        if (!(imem_req2 === 1'b1 && imem_addr2 === 16'h0000)) begin
            failures++; $display("FAIL wrap_second: got req=%b addr=%0h want 1/0", imem_req2, imem_addr2);
        end
        checks++;
        if (!(instr_valid2 === 1'b1 && instr_pc2 === 16'hFFFF && instr2 === word_of(16'hFFFF))) begin
            failures++; $display("FAIL wrap_head: got v=%b pc=%0h want pc ffff", instr_valid2, instr_pc2);
        end
        step();
        checks++;
        if (!(imem_req2 === 1'b1 && imem_addr2 === 16'h0000)) begin
            failures++; $display("FAIL wrap_wait: got req=%b addr=%0h want 1/0", imem_req2, imem_addr2);
        end
        #2 rst2_n = 1'b0; #1;
        checks++;
        if (!(imem_req2 === 1'b0 && imem_addr2 === 16'hFFFF && instr_valid2 === 1'b0)) begin
            failures++; $display("FAIL wrap_async: got req=%b addr=%0h v=%b want 0/ffff/0", imem_req2, imem_addr2, instr_valid2);
        end
        rst2_n = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] exp = 16'h0, prev_addr = 16'h0, rpc;
        logic        prev_req = 1'b0, prev_ack = 1'b0, m_halted = 1'b0, rdy, do_redir, do_halt;
        int          consumed = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            mem_lat = $urandom_range(0, 2);
            if (prev_req && !prev_ack) begin
                checks++;
                if (!(imem_req === 1'b1 && imem_addr === prev_addr)) begin
                    failures++; $display("FAIL rnd_hold: got req=%b addr=%0h want 1/%0h", imem_req, imem_addr, prev_addr);
                end
            end
            if (m_halted) begin
                checks++;
                if (!(halted === 1'b1 && instr_valid === 1'b0)) begin
                    failures++; $display("FAIL rnd_halted: got halted=%b v=%b want 1/0", halted, instr_valid);
                end
                checks++;
                if (imem_req && !(prev_req && !prev_ack)) begin
                    failures++; $display("FAIL rnd_halt_req: got new req addr=%0h want none", imem_addr);
                end
            end else begin
                checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rnd_run: got halted=%b want 0", halted); end
                if (instr_valid) begin
                    checks++;
                    if (!(instr_pc === exp && instr === word_of(exp))) begin
                        failures++; $display("FAIL rnd_stream: got pc=%0h w=%0h want pc %0h", instr_pc, instr, exp);
                    end
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            do_redir = ($urandom_range(0, 19) == 0);
            do_halt = ($urandom_range(0, 24) == 0);
            rpc = 16'($urandom_range(0, 16'h07FF));
            instr_ready = rdy; pc_halt = do_halt; redirect = do_redir; redirect_pc = rpc;
            if (do_redir) begin
                exp = rpc; m_halted = 1'b0;
            end else if (!m_halted && instr_valid) begin
                if (do_halt) m_halted = 1'b1;
                else if (rdy) begin exp++; consumed++; end
            end
            prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
            step();
        end
        redirect = 1'b0; pc_halt = 1'b0;
        checks++; if (consumed < 50) begin failures++; $display("FAIL rnd_progress: got %0d words want >= 50", consumed); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_late_ack();
        test_halt_redirect();
        test_redirect_wait();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
